// File: rtl/frame_dumper_pkg.sv
// Shared constants for the frame dumper: default frame geometry, pixel width
// and the capture FSM state encoding.
package frame_dumper_pkg;

  localparam int DEF_PX_WIDTH  = 640;
  localparam int DEF_PX_HEIGHT = 480;
  localparam int DEF_PIX_BITS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Counter width that stays legal (>= 1 bit) for a dimension of 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_dumper_tick_sync.sv
// Two-flop synchroniser for the render clock level plus a falling-edge
// detector; o_tick is a one-clk pulse.
module tick_sync (
  input  logic clk,
  input  logic clr,
  input  logic i_level,
  output logic o_tick
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_level;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Consumed at the third clk edge after the raw falling edge.
  assign o_tick = r_s3 & ~r_s2;

endmodule

// File: rtl/frame_dumper.sv
// Captures one framebuffer image per accepted render tick and streams it out
// pixel by pixel over a valid/ready interface with frame markers.
//
// state | meaning
// IDLE  | waiting for a tick; counts down skipped frames
// FETCH | rd_addr presented to the framebuffer
// WAIT  | read data returning; loaded into the output register
// HOLD  | pixel offered downstream until accepted
module frame_dumper
  import frame_dumper_pkg::*;
#(
  parameter int PX_WIDTH  = DEF_PX_WIDTH,
  parameter int PX_HEIGHT = DEF_PX_HEIGHT,
  parameter int PIX_BITS  = DEF_PIX_BITS,
  parameter int ADDR_W    = 19,
  parameter int SKIP_W    = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic [SKIP_W-1:0]   skip_n,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [PIX_BITS-1:0] rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PIX_BITS-1:0] out_data,
  output logic                out_sof,
  output logic                out_last,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic [7:0]          overrun_cnt
);

  localparam int X_W = clog2_min1(PX_WIDTH);
  localparam int Y_W = clog2_min1(PX_HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(PX_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(PX_HEIGHT - 1);

  state_t r_state;
  state_t w_next;

  logic                w_tick;
  logic                w_start;
  logic                w_beat;
  logic                w_x_end;
  logic                w_y_end;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [ADDR_W-1:0]   r_addr;
  logic [SKIP_W-1:0]   r_skip;
  logic                r_valid;
  logic                r_sof;
  logic                r_last;
  logic [PIX_BITS-1:0] r_data;
  logic [15:0]         r_frame_cnt;
  logic [7:0]          r_overrun;

  tick_sync u_tick_sync (
    .clk     (clk),
    .clr     (clr),
    .i_level (frame_tick),
    .o_tick  (w_tick)
  );

  assign w_x_end = (r_x == X_LAST);
  assign w_y_end = (r_y == Y_LAST);
  assign w_start = (r_state == ST_IDLE) && w_tick && enable && (r_skip == '0);
  assign w_beat  = (r_state == ST_HOLD) && r_valid && out_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_HOLD;
      ST_HOLD:  if (w_beat) w_next = (w_x_end && w_y_end) ? ST_IDLE : ST_FETCH;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_skip      <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= '0;
      r_frame_cnt <= '0;
      r_overrun   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_tick && enable) begin
            if (r_skip == '0) begin
              r_skip <= skip_n;
              r_x    <= '0;
              r_y    <= '0;
              r_addr <= '0;
            end else begin
              r_skip <= r_skip - 1'b1;
            end
          end
        end
        ST_WAIT: begin
          r_data  <= rd_data;
          r_valid <= 1'b1;
          r_sof   <= (r_x == '0) && (r_y == '0);
          r_last  <= w_x_end && w_y_end;
        end
        ST_HOLD: begin
          if (w_beat) begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_last  <= 1'b0;
            if (w_x_end) begin
              r_x <= '0;
              r_y <= w_y_end ? '0 : r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
            // Running address replaces the y*PX_WIDTH+x product.
            if (w_x_end && w_y_end) begin
              r_addr      <= '0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (w_tick && (r_state != ST_IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;
    end
  end

  assign rd_addr     = r_addr;
  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_sof     = r_sof;
  assign out_last    = r_last;
  assign busy        = (r_state != ST_IDLE);
  assign frame_cnt   = r_frame_cnt;
  assign overrun_cnt = r_overrun;

endmodule
